// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct encodings, ALU op enum and decode control bundle.
package mips_pkg;

  localparam int         ALU_OP_W = 4;
  localparam logic [4:0] LINK_REG = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASS
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    is_load;
    logic    is_store;
    logic    reg_write;
    logic    branch;
    logic    jump;
    logic    is_jal;
    logic    uses_rt;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - combinational instruction decode: ALU op, destination, immediate, control flags.
module decode_ctrl
  import mips_pkg::*;
#(
  parameter logic [4:0] LINK = LINK_REG
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [4:0]  rd,
  output logic [31:0] imm
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [31:0] sext;
  logic [31:0] zext;

  assign op   = instr[31:26];
  assign fn   = instr[5:0];
  assign sext = {{16{instr[15]}}, instr[15:0]};
  assign zext = {16'h0000, instr[15:0]};

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_PASS;
    rd          = instr[20:16];
    imm         = sext;
    case (op)
      OP_RTYPE: begin
        rd             = instr[15:11];
        imm            = {27'd0, instr[10:6]};
        ctrl.uses_rt   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_XOR:          ctrl.alu_op = ALU_XOR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLL:          ctrl.alu_op = ALU_SLL;
          FN_SRL:          ctrl.alu_op = ALU_SRL;
          FN_SRA:          ctrl.alu_op = ALU_SRA;
          default:         ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin ctrl.alu_op = ALU_ADD; ctrl.reg_write = 1'b1; end
      OP_SLTI:           begin ctrl.alu_op = ALU_SLT; ctrl.reg_write = 1'b1; end
      OP_ANDI: begin ctrl.alu_op = ALU_AND; ctrl.reg_write = 1'b1; imm = zext; end
      OP_ORI:  begin ctrl.alu_op = ALU_OR;  ctrl.reg_write = 1'b1; imm = zext; end
      OP_XORI: begin ctrl.alu_op = ALU_XOR; ctrl.reg_write = 1'b1; imm = zext; end
      OP_LUI: begin
        ctrl.alu_op    = ALU_LUI;
        ctrl.reg_write = 1'b1;
        imm            = {instr[15:0], 16'h0000};
      end
      OP_LW: begin ctrl.alu_op = ALU_ADD; ctrl.is_load = 1'b1; ctrl.reg_write = 1'b1; end
      OP_SW: begin ctrl.alu_op = ALU_ADD; ctrl.is_store = 1'b1; ctrl.uses_rt = 1'b1; end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.branch  = 1'b1;
        ctrl.uses_rt = 1'b1;
        imm          = {sext[29:0], 2'b00};
      end
      OP_J: begin
        ctrl.jump = 1'b1;
        imm       = {4'h0, instr[25:0], 2'b00};
      end
      // JAL carries the return address through operand A with a PASS op
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.is_jal    = 1'b1;
        ctrl.reg_write = 1'b1;
        rd             = LINK;
        imm            = {4'h0, instr[25:0], 2'b00};
      end
      default: ;
    endcase
    if (rd == 5'd0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: decode, WB bypass, load-use hazard, ID/EX pipeline register.
module decode_stage
  import mips_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         ALU_OP_W = 4,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_valid,
  input  logic [31:0]         i_pc_32,
  input  logic [31:0]         i_instr_32,
  output logic                o_ready,
  output logic [4:0]          o_rs_addr_5,
  output logic [4:0]          o_rt_addr_5,
  input  logic [DATA_W-1:0]   i_rs_val_32,
  input  logic [DATA_W-1:0]   i_rt_val_32,
  input  logic                i_wb_en,
  input  logic [4:0]          i_wb_addr_5,
  input  logic [DATA_W-1:0]   i_wb_data_32,
  input  logic                i_ex_is_load,
  input  logic [4:0]          i_ex_rd_5,
  input  logic                i_stall,
  input  logic                i_flush,
  output logic                o_valid,
  output logic [31:0]         o_pc_32,
  output logic [DATA_W-1:0]   o_rs_val_32,
  output logic [DATA_W-1:0]   o_rt_val_32,
  output logic [DATA_W-1:0]   o_imm_32,
  output logic [4:0]          o_rd_5,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_is_load,
  output logic                o_is_store,
  output logic                o_reg_write,
  output logic                o_branch,
  output logic                o_jump
);

  ctrl_t             ctrl;
  logic [4:0]        dec_rd;
  logic [31:0]       dec_imm;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic              hazard;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  decode_ctrl #(.LINK(LINK_REG)) u_ctrl (
    .instr (i_instr_32),
    .ctrl  (ctrl),
    .rd    (dec_rd),
    .imm   (dec_imm)
  );

  assign rs          = i_instr_32[25:21];
  assign rt          = i_instr_32[20:16];
  assign o_rs_addr_5 = rs;
  assign o_rt_addr_5 = rt;

  assign hazard = i_valid & i_ex_is_load & o_valid & (i_ex_rd_5 != 5'd0) &
                  ((i_ex_rd_5 == rs) | ((i_ex_rd_5 == rt) & ctrl.uses_rt));
  assign o_ready = !i_stall & !hazard;

  // The register file writes on the same edge we capture, so forward WB data
  always_comb begin
    op_a = i_rs_val_32;
    if (rs == 5'd0)                          op_a = '0;
    else if (i_wb_en && i_wb_addr_5 == rs)   op_a = i_wb_data_32;
    if (ctrl.is_jal)                         op_a = DATA_W'(i_pc_32 + 32'd8);
    op_b = i_rt_val_32;
    if (rt == 5'd0)                          op_b = '0;
    else if (i_wb_en && i_wb_addr_5 == rt)   op_b = i_wb_data_32;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_valid     <= 1'b0;
      o_pc_32     <= '0;
      o_rs_val_32 <= '0;
      o_rt_val_32 <= '0;
      o_imm_32    <= '0;
      o_rd_5      <= '0;
      o_alu_op    <= '0;
      o_is_load   <= 1'b0;
      o_is_store  <= 1'b0;
      o_reg_write <= 1'b0;
      o_branch    <= 1'b0;
      o_jump      <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_stall) begin
      o_valid <= o_valid;
    end else if (hazard) begin
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
      o_is_load   <= 1'b0;
      o_is_store  <= 1'b0;
    end else begin
      o_valid     <= i_valid;
      o_pc_32     <= i_pc_32;
      o_rs_val_32 <= op_a;
      o_rt_val_32 <= op_b;
      o_imm_32    <= DATA_W'(dec_imm);
      o_rd_5      <= dec_rd;
      o_alu_op    <= ALU_OP_W'(ctrl.alu_op);
      o_is_load   <= ctrl.is_load;
      o_is_store  <= ctrl.is_store;
      o_reg_write <= ctrl.reg_write;
      o_branch    <= ctrl.branch;
      o_jump      <= ctrl.jump;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage.
module tb_decode_stage;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic [31:0] i_pc_32, i_instr_32;
  logic        o_ready;
  logic [4:0]  o_rs_addr_5, o_rt_addr_5;
  logic [31:0] i_rs_val_32, i_rt_val_32;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr_5;
  logic [31:0] i_wb_data_32;
  logic        i_ex_is_load;
  logic [4:0]  i_ex_rd_5;
  logic        i_stall, i_flush;
  logic        o_valid;
  logic [31:0] o_pc_32, o_rs_val_32, o_rt_val_32, o_imm_32;
  logic [4:0]  o_rd_5;
  logic [3:0]  o_alu_op;
  logic        o_is_load, o_is_store, o_reg_write, o_branch, o_jump;

  always #5 clock = ~clock;

  decode_stage dut (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .i_pc_32(i_pc_32),
    .i_instr_32(i_instr_32), .o_ready(o_ready), .o_rs_addr_5(o_rs_addr_5),
    .o_rt_addr_5(o_rt_addr_5), .i_rs_val_32(i_rs_val_32), .i_rt_val_32(i_rt_val_32),
    .i_wb_en(i_wb_en), .i_wb_addr_5(i_wb_addr_5), .i_wb_data_32(i_wb_data_32),
    .i_ex_is_load(i_ex_is_load), .i_ex_rd_5(i_ex_rd_5), .i_stall(i_stall),
    .i_flush(i_flush), .o_valid(o_valid), .o_pc_32(o_pc_32), .o_rs_val_32(o_rs_val_32),
    .o_rt_val_32(o_rt_val_32), .o_imm_32(o_imm_32), .o_rd_5(o_rd_5), .o_alu_op(o_alu_op),
    .o_is_load(o_is_load), .o_is_store(o_is_store), .o_reg_write(o_reg_write),
    .o_branch(o_branch), .o_jump(o_jump)
  );

  typedef struct {
    string       name;
    logic [31:0] pc, a, b, imm;
    bit          chk_imm;
    logic [4:0]  rd;
    logic [3:0]  op;
    bit          ld, st, rw, br, j;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic [31:0] pc, a, b, imm, input bit ci,
                              input logic [4:0] rd, input logic [3:0] op,
                              input bit ld, st, rw, br, j);
    exp_t e;
    e.name = n; e.pc = pc; e.a = a; e.b = b; e.imm = imm; e.chk_imm = ci;
    e.rd = rd; e.op = op; e.ld = ld; e.st = st; e.rw = rw; e.br = br; e.j = j;
    return e;
  endfunction

  task automatic cycle(input bit capture);
    exp_t e;
    @(posedge clock);
    #1;
    if (capture) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, ".valid"}, 32'(o_valid), 32'd1);
        check({e.name, ".pc"}, o_pc_32, e.pc);
        check({e.name, ".a"}, o_rs_val_32, e.a);
        check({e.name, ".b"}, o_rt_val_32, e.b);
        if (e.chk_imm) check({e.name, ".imm"}, o_imm_32, e.imm);
        check({e.name, ".rd"}, 32'(o_rd_5), 32'(e.rd));
        check({e.name, ".alu_op"}, 32'(o_alu_op), 32'(e.op));
        check({e.name, ".ctrl"},
              32'({o_is_load, o_is_store, o_reg_write, o_branch, o_jump}),
              32'({e.ld, e.st, e.rw, e.br, e.j}));
      end
    end
  endtask

  task automatic drive(input logic [31:0] instr, pc, rsv, rtv);
    i_valid = 1'b1; i_instr_32 = instr; i_pc_32 = pc;
    i_rs_val_32 = rsv; i_rt_val_32 = rtv;
  endtask

  task automatic issue(input logic [31:0] instr, pc, rsv, rtv, input exp_t e);
    drive(instr, pc, rsv, rtv);
    sb.push_back(e);
    #1;
    check({e.name, ".ready"}, 32'(o_ready), 32'd1);
    cycle(1'b1);
  endtask

  localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;
  localparam logic [31:0] ADD_3_0_2 = 32'h0002_1820;
  localparam logic [31:0] SUB_6_5_4 = 32'h00A4_3022;
  localparam logic [31:0] LW_5      = 32'h8C25_0004;

  initial begin
    reset_n = 1'b1; i_valid = 1'b0; i_pc_32 = '0; i_instr_32 = '0;
    i_rs_val_32 = '0; i_rt_val_32 = '0; i_wb_en = 1'b0; i_wb_addr_5 = '0;
    i_wb_data_32 = '0; i_ex_is_load = 1'b0; i_ex_rd_5 = '0; i_stall = 1'b0; i_flush = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.pc", o_pc_32, 32'd0);
    check("rst.a", o_rs_val_32, 32'd0);
    check("rst.imm", o_imm_32, 32'd0);
    check("rst.rd", 32'(o_rd_5), 32'd0);
    check("rst.ctrl", 32'({o_alu_op, o_is_load, o_is_store, o_reg_write, o_branch, o_jump}), 32'd0);
    reset_n = 1'b1;

    issue(ADD_3_1_2, 32'h40, 32'd1, 32'd2,
          mk("add", 32'h40, 32'd1, 32'd2, 0, 0, 5'd3, ALU_ADD, 0, 0, 1, 0, 0));

    // asynchronous reset between edges while a valid add sits in ID/EX
    #2 reset_n = 1'b0;
    #1;
    check("midrst.valid", 32'(o_valid), 32'd0);
    check("midrst.a", o_rs_val_32, 32'd0);
    check("midrst.rd", 32'(o_rd_5), 32'd0);
    check("midrst.rw", 32'(o_reg_write), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    issue(ADD_3_1_2, 32'h44, 32'd1, 32'd2,
          mk("add_after_rst", 32'h44, 32'd1, 32'd2, 0, 0, 5'd3, ALU_ADD, 0, 0, 1, 0, 0));

    i_wb_en = 1'b1; i_wb_addr_5 = 5'd1; i_wb_data_32 = 32'hDEAD_BEEF;
    issue(ADD_3_1_2, 32'h48, 32'd1, 32'd2,
          mk("bypass_rs", 32'h48, 32'hDEAD_BEEF, 32'd2, 0, 0, 5'd3, ALU_ADD, 0, 0, 1, 0, 0));
    i_wb_addr_5 = 5'd0;
    issue(ADD_3_0_2, 32'h4C, 32'h55, 32'd2,
          mk("bypass_r0", 32'h4C, 32'd0, 32'd2, 0, 0, 5'd3, ALU_ADD, 0, 0, 1, 0, 0));
    i_wb_en = 1'b0;

    // load in EX writes $5, sub reads $5
    i_ex_is_load = 1'b1; i_ex_rd_5 = 5'd5;
    drive(SUB_6_5_4, 32'h50, 32'd7, 32'd9);
    #1 check("loaduse.ready", 32'(o_ready), 32'd0);
    cycle(1'b0);
    check("bubble.valid", 32'(o_valid), 32'd0);
    check("bubble.rw", 32'(o_reg_write), 32'd0);
    i_ex_is_load = 1'b0;
    i_wb_en = 1'b1; i_wb_addr_5 = 5'd4; i_wb_data_32 = 32'h44;
    issue(SUB_6_5_4, 32'h50, 32'd7, 32'd9,
          mk("sub_after_bubble", 32'h50, 32'd7, 32'h44, 0, 0, 5'd6, ALU_SUB, 0, 0, 1, 0, 0));
    i_wb_en = 1'b0;

    // rt=5 is only a destination for addi, so no hazard
    i_ex_is_load = 1'b1; i_ex_rd_5 = 5'd5;
    issue(32'h2025_0001, 32'h54, 32'd3, 32'h99,
          mk("addi_no_hazard", 32'h54, 32'd3, 32'h99, 32'd1, 1, 5'd5, ALU_ADD, 0, 0, 1, 0, 0));
    i_ex_is_load = 1'b0;

    issue(32'h3402_8000, 32'h60, 32'h11, 32'h22,
          mk("ori", 32'h60, 32'd0, 32'h22, 32'h0000_8000, 1, 5'd2, ALU_OR, 0, 0, 1, 0, 0));
    issue(32'h2002_8000, 32'h64, 32'h11, 32'h22,
          mk("addi", 32'h64, 32'd0, 32'h22, 32'hFFFF_8000, 1, 5'd2, ALU_ADD, 0, 0, 1, 0, 0));
    issue(32'h3C02_1234, 32'h68, 32'h11, 32'h22,
          mk("lui", 32'h68, 32'd0, 32'h22, 32'h1234_0000, 1, 5'd2, ALU_LUI, 0, 0, 1, 0, 0));
    issue(LW_5, 32'h6C, 32'h1000, 32'h50,
          mk("lw", 32'h6C, 32'h1000, 32'h50, 32'd4, 1, 5'd5, ALU_ADD, 1, 0, 1, 0, 0));
    issue(32'hAC25_FFFC, 32'h70, 32'h1000, 32'h51,
          mk("sw", 32'h70, 32'h1000, 32'h51, 32'hFFFF_FFFC, 1, 5'd5, ALU_ADD, 0, 1, 0, 0, 0));
    issue(32'h1022_FFFF, 32'h74, 32'd1, 32'd2,
          mk("beq", 32'h74, 32'd1, 32'd2, 32'hFFFF_FFFC, 1, 5'd2, ALU_SUB, 0, 0, 0, 1, 0));
    issue(32'hFC22_1800, 32'h78, 32'd1, 32'd2,
          mk("bad_opcode", 32'h78, 32'd1, 32'd2, 0, 0, 5'd2, ALU_PASS, 0, 0, 0, 0, 0));
    issue(32'h0022_183F, 32'h7C, 32'd1, 32'd2,
          mk("bad_funct", 32'h7C, 32'd1, 32'd2, 0, 0, 5'd3, ALU_PASS, 0, 0, 0, 0, 0));
    issue(32'h0022_0020, 32'h80, 32'd1, 32'd2,
          mk("add_to_r0", 32'h80, 32'd1, 32'd2, 0, 0, 5'd0, ALU_ADD, 0, 0, 0, 0, 0));

    issue(32'h3C02_1234, 32'h200, 32'h0, 32'h0,
          mk("lui_pre_stall", 32'h200, 32'd0, 32'd0, 32'h1234_0000, 1, 5'd2, ALU_LUI, 0, 0, 1, 0, 0));
    i_stall = 1'b1;
    drive(32'h3402_8000, 32'h204, 32'h0, 32'h0);
    #1 check("stall.ready", 32'(o_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0);
      check($sformatf("stall%0d.valid", k), 32'(o_valid), 32'd1);
      check($sformatf("stall%0d.pc", k), o_pc_32, 32'h200);
      check($sformatf("stall%0d.imm", k), o_imm_32, 32'h1234_0000);
      check($sformatf("stall%0d.op", k), 32'(o_alu_op), 32'(ALU_LUI));
    end
    i_flush = 1'b1;
    cycle(1'b0);
    check("flush_over_stall.valid", 32'(o_valid), 32'd0);
    i_flush = 1'b0; i_stall = 1'b0;

    issue(LW_5, 32'h300, 32'h1000, 32'h0,
          mk("lw_pre_flush", 32'h300, 32'h1000, 32'h0, 32'd4, 1, 5'd5, ALU_ADD, 1, 0, 1, 0, 0));
    i_ex_is_load = 1'b1; i_ex_rd_5 = 5'd5; i_flush = 1'b1;
    drive(SUB_6_5_4, 32'h304, 32'd7, 32'd9);
    #1 check("flush_hazard.ready", 32'(o_ready), 32'd0);
    cycle(1'b0);
    check("flush_hazard.valid", 32'(o_valid), 32'd0);
    i_ex_is_load = 1'b0; i_flush = 1'b0;

    issue(32'h0C00_0040, 32'h100, 32'h33, 32'h77,
          mk("jal", 32'h100, 32'h108, 32'd0, 0, 0, 5'd31, ALU_PASS, 0, 0, 1, 0, 1));
    issue(32'h0C00_0040, 32'hFFFF_FFFC, 32'h33, 32'h77,
          mk("jal_wrap", 32'hFFFF_FFFC, 32'd4, 32'd0, 0, 0, 5'd31, ALU_PASS, 0, 0, 1, 0, 1));

    i_valid = 1'b0;
    cycle(1'b0);
    check("idle.valid", 32'(o_valid), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
